mdu_param: RTL and testbench
============================

Name: mdu_param

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the EX stage of the pipelined MIPS core.
- Successor to the fixed 32-bit, fixed-latency mult/div unit: data width and per-class latency are parameters, and it adds a start/busy handshake, cancel support and divide-by-zero handling.
- The hazard controller stalls the D stage on `busy`/`start` when the D-stage instruction is a mult/div/mfhi/mflo/mthi/mtlo.
- The EX result mux selects `hl_out` for mfhi/mflo.

Parameters:
- DATA_W, 32, operand and HI/LO width (any even value ≥ 8).
- MULT_LAT, 5, cycles from accepted mult/multu to result visible; must be ≥ 1.
- DIV_LAT, 10, cycles from accepted div/divu to result visible; must be ≥ 1.
- CNT_W, 8, busy-counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation code. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo. Codes 9-15 are treated as none.
- rs  input  DATA_W  forwarded rs operand.
- rt  input  DATA_W  forwarded rt operand.
- cancel  input  1  abort the in-flight operation (the EX instruction was flushed).
- start  output  1  combinational; high when md_op is 1-4 and `busy` is 0 (operation accepted this cycle).
- busy  output  1  registered; high while an operation is in flight.
- hl_out  output  DATA_W  combinational. HI when md_op=7, LO when md_op=8, else 0.
- hi  output  DATA_W  architectural HI register.
- lo  output  DATA_W  architectural LO register.
- div_zero  output  1  registered one-cycle pulse: a div/divu with rt=0 completed.

Behaviour:
- Reset, synchronous, highest priority: hi=0, lo=0, busy=0, counter=0, pending result=0, div_zero=0. A reset during an operation discards it; HI/LO stay 0.
- State machine:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE → RUN on a clock edge where `start`=1 and `cancel`=0:
  - Operands are latched.
  - The result is computed into internal pending registers.
  - Counter loads LAT-1, where LAT is MULT_LAT for codes 1-2 and DIV_LAT for codes 3-4.
- Latency: for a start at edge k, HI/LO update at edge k+LAT and busy falls at that same edge. Busy is high for exactly LAT cycles.
- RUN: the counter decrements each edge. When the counter is 0 the edge commits pending→HI/LO and returns to IDLE.
- Arithmetic:
  - mult: signed DATA_W×DATA_W → 2·DATA_W product; {HI,LO} = product.
  - multu: the same, unsigned.
  - div: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - divu: the same, unsigned.
  - Signed most-negative / -1: LO = most-negative, HI = 0 (no trap).
- Divide by zero (rt=0 on div/divu):
  - Still occupies DIV_LAT cycles.
  - HI/LO keep their prior values at commit.
  - div_zero pulses for one cycle on the commit edge.
- mthi/mtlo:
  - Write rs to HI/LO on the next edge when busy=0.
  - When busy=1 they are ignored; the hazard controller must stall them.
- mfhi/mflo:
  - hl_out reflects the current register value.
  - There is no internal bypass of a pending result.
- md_op 1-4 while busy=1: ignored; start=0 and the in-flight operation is unaffected.
- cancel while in RUN: the next edge returns to IDLE, busy=0, HI/LO unchanged, no div_zero pulse.
- cancel in the same cycle as start: the operation is not accepted.
- cancel in IDLE: no effect; mthi/mtlo in that cycle are also suppressed.
- The commit edge and a new md_op share no resources. A new start is only possible on the cycle after busy falls.

Optional Feature:
- MDU_MADD_EN defined:
  - Adds md_op 9 madd, 10 maddu, 11 msub, 12 msubu.
  - {HI,LO} ± product, modulo 2^(2·DATA_W), using MULT_LAT.
  - The HI/LO accumulate base is sampled at commit, not at start.
- MDU_MADD_EN undefined: codes 9-12 are treated as none (start=0, no state change).

Test Plan:
- Reset, then mult rs=0xFFFFFFFE rt=3 (DATA_W=32, MULT_LAT=5):
  - busy high 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - hl_out with md_op=7 reads 0xFFFFFFFF.
- div rs=-7 rt=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=7 rt=2 → LO=3, HI=1.
- After mtlo 0x1234, div rs=5 rt=0 → busy 10 cycles, LO stays 0x1234, div_zero pulses exactly 1 cycle.
- mult started, cancel at cycle 2 → busy 0 next cycle, HI/LO unchanged. A second mult issued while busy is ignored (start=0).
- Reset asserted at cycle 3 of an in-flight divu → hi=lo=0, busy=0 on the next edge. A subsequent mthi 0xAA lands in HI one edge later.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd rs=1 rt=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same op leaves HI/LO unchanged and start=0.

Source files
------------

// File: rtl/mdu_param.sv
// mdu_param: parametrised multi-cycle multiply/divide unit with HI/LO
// registers for the EX stage. Operations run for MULT_LAT or DIV_LAT
// cycles behind a start/busy handshake and can be cancelled in flight.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu (codes 9-12)
// that accumulate into {HI,LO}.
module mdu_param #(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        md_op,
  input  logic [DATA_W-1:0] rs,
  input  logic [DATA_W-1:0] rt,
  input  logic              cancel,
  output logic              start,
  output logic              busy,
  output logic [DATA_W-1:0] hl_out,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              div_zero
);

  localparam int PW = 2 * DATA_W;

  typedef enum logic {S_IDLE, S_RUN} state_t;
  typedef enum logic [1:0] {ACC_NONE, ACC_ADD, ACC_SUB} acc_t;

  // Full-width product. Operands are extended by the requested signedness;
  // modulo 2^PW the unsigned product of the extended values equals the
  // signed product.
  function automatic logic [PW-1:0] mul_full(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              sgn);
    logic [PW-1:0] ea;
    logic [PW-1:0] eb;
    ea = {{DATA_W{sgn & a[DATA_W-1]}}, a};
    eb = {{DATA_W{sgn & b[DATA_W-1]}}, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes and
  // restores signs afterwards: quotient truncates toward zero, remainder
  // follows the dividend. most-negative / -1 falls out as most-negative, 0.
  function automatic logic [PW-1:0] div_full(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b,
                                             input logic              sgn);
    logic              na;
    logic              nb;
    logic [DATA_W-1:0] ua;
    logic [DATA_W-1:0] ub;
    logic [DATA_W-1:0] uq;
    logic [DATA_W-1:0] ur;
    na = sgn & a[DATA_W-1];
    nb = sgn & b[DATA_W-1];
    ua = na ? -a : a;
    ub = nb ? -b : b;
    // A zero divisor never commits; substitute 1 so the divider stays defined.
    if (ub == '0) ub = {{(DATA_W-1){1'b0}}, 1'b1};
    uq = ua / ub;
    ur = ua % ub;
    if (na ^ nb) uq = -uq;
    if (na) ur = -ur;
    return {ur, uq};
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]     pend_q, pend_d;
  acc_t              acc_q, acc_d;
  logic              dz_q, dz_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              div_zero_q, div_zero_d;

  logic is_mul;
  logic is_div;
  logic sgn;
  acc_t acc;
  logic wr_hi;
  logic wr_lo;

  // Decode the operation code into operation class and signedness.
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    acc    = ACC_NONE;
    wr_hi  = 1'b0;
    wr_lo  = 1'b0;
    case (md_op)
      4'd1: begin is_mul = 1'b1; sgn = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; sgn = 1'b1; end
      4'd4: is_div = 1'b1;
      4'd5: wr_hi = 1'b1;
      4'd6: wr_lo = 1'b1;
`ifdef MDU_MADD_EN
      4'd9:  begin is_mul = 1'b1; sgn = 1'b1; acc = ACC_ADD; end
      4'd10: begin is_mul = 1'b1; acc = ACC_ADD; end
      4'd11: begin is_mul = 1'b1; sgn = 1'b1; acc = ACC_SUB; end
      4'd12: begin is_mul = 1'b1; acc = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign start    = (is_mul | is_div) & ~busy;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = div_zero_q;

  // Read port for mfhi/mflo; no bypass of a pending result.
  always_comb begin
    hl_out = '0;
    case (md_op)
      4'd7:    hl_out = hi_q;
      4'd8:    hl_out = lo_q;
      default: ;
    endcase
  end

  // Next-state logic: accept, count down, commit or abort.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    acc_d      = acc_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A cancel in IDLE suppresses both a start and an mthi/mtlo.
        if (!cancel) begin
          if (start) begin
            state_d = S_RUN;
            acc_d   = acc;
            if (is_div) begin
              cnt_d  = CNT_W'(DIV_LAT - 1);
              pend_d = div_full(rs, rt, sgn);
              dz_d   = (rt == '0);
            end else begin
              cnt_d  = CNT_W'(MULT_LAT - 1);
              pend_d = mul_full(rs, rt, sgn);
              dz_d   = 1'b0;
            end
          end else begin
            if (wr_hi) hi_d = rs;
            if (wr_lo) lo_d = rs;
          end
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (dz_q) begin
            div_zero_d = 1'b1;
          end else begin
            // Accumulate base is whatever HI/LO hold at the commit edge.
            case (acc_q)
              ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
              ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
              default: {hi_d, lo_d} = pend_q;
            endcase
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // State registers; reset clears everything and discards any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      acc_q      <= ACC_NONE;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      acc_q      <= acc_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_mdu_param.sv
// tb_mdu_param: scoreboard bench for mdu_param (DATA_W=32, MULT_LAT=5,
// DIV_LAT=10). Issue tasks push the expected outcome of each operation;
// a monitor pops it when busy falls.
module tb_mdu_param;
  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   md_op;
  logic [W-1:0] rs;
  logic [W-1:0] rt;
  logic         cancel;
  logic         start;
  logic         busy;
  logic [W-1:0] hl_out;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  mdu_param #(.DATA_W(W), .MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs(rs), .rt(rt),
    .cancel(cancel), .start(start), .busy(busy), .hl_out(hl_out),
    .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           len;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] mh = '0;
  logic [W-1:0] ml = '0;
  logic         mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural HI/LO.
  function automatic void ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl,
                                 output logic dz);
    logic [2*W-1:0] p;
    logic [2*W-1:0] base;
    base = {mh, ml};
    rh = mh;
    rl = ml;
    dz = 1'b0;
    if (op == 1 || op == 9 || op == 11) p = 64'($signed(a)) * 64'($signed(b));
    else p = 64'(a) * 64'(b);
    case (op)
      1, 2:   {rh, rl} = p;
      9, 10:  {rh, rl} = base + p;
      11, 12: {rh, rl} = base - p;
      3: begin
        if (b == '0) dz = 1'b1;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin rl = a; rh = '0; end
        else begin
          rl = W'($signed(a) / $signed(b));
          rh = W'($signed(a) % $signed(b));
        end
      end
      4: begin
        if (b == '0) dz = 1'b1;
        else begin rl = a / b; rh = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Monitor: on every busy fall compare HI/LO, div_zero and busy length.
  initial begin
    logic bprev;
    int   cnt;
    exp_t e;
    bprev = 1'b0;
    cnt   = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bprev && !busy) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: busy fell, got no pending op expected one");
          end else begin
            e = sb.pop_front();
            chk("commit_hi", 64'(hi), 64'(e.hi));
            chk("commit_lo", 64'(lo), 64'(e.lo));
            chk("div_zero_pulse", 64'(div_zero), 64'(e.dz));
            chk("busy_len", 64'(cnt), 64'(e.len));
          end
          cnt = 0;
        end else if (div_zero) begin
          n_vec++;
          n_err++;
          $display("FAIL stray_div_zero: got 1 expected 0");
        end
        if (busy) cnt++;
        bprev = busy;
      end
    end
  end

  // Issue one mult/div class op; optionally stop it at busy cycle stop_at
  // by cancel or reset, and optionally present an interfering op (iop)
  // in the first busy cycle.
  task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stop_at, input bit use_reset, input int iop);
    exp_t e;
    int   lat;
    lat = (op == 3 || op == 4) ? DL : ML;
    if (stop_at > 0) begin
      if (use_reset) begin mh = '0; ml = '0; end
      e.hi  = mh;
      e.lo  = ml;
      e.dz  = 1'b0;
      e.len = stop_at;
    end else begin
      ref_op(op, a, b, e.hi, e.lo, e.dz);
      e.len = lat;
      if (!e.dz) begin mh = e.hi; ml = e.lo; end
    end
    sb.push_back(e);
    md_op = 4'(op); rs = a; rt = b; cancel = 1'b0;
    #1;
    chk("start", 64'(start), 64'(1));
    @(posedge clk); #1;
    md_op = 4'd0;
    if (iop != 0) begin
      md_op = 4'(iop); rs = $urandom; rt = $urandom;
      #1;
      if (iop <= 4) chk("start_while_busy", 64'(start), 64'(0));
    end
    for (int i = 1; i <= lat + 2; i++) begin
      if (i == stop_at) begin
        if (use_reset) reset = 1'b1;
        else cancel = 1'b1;
      end
      @(posedge clk); #1;
      md_op = 4'd0; reset = 1'b0; cancel = 1'b0;
      if (!busy) break;
    end
    if (busy) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within %0d cycles", lat + 2);
      $fatal(1, "busy stuck");
    end
  endtask

  task automatic mt(input int op, input logic [W-1:0] v, input bit cxl);
    md_op = 4'(op); rs = v; cancel = cxl;
    #1;
    chk("start_mt", 64'(start), 64'(0));
    @(posedge clk); #1;
    md_op = 4'd0; cancel = 1'b0;
    if (!cxl) begin
      if (op == 5) mh = v;
      else ml = v;
    end
    chk("mt_hi", 64'(hi), 64'(mh));
    chk("mt_lo", 64'(lo), 64'(ml));
    chk("mt_busy", 64'(busy), 64'(0));
  endtask

  task automatic readback();
    md_op = 4'd7; #1;
    chk("mfhi", 64'(hl_out), 64'(mh));
    md_op = 4'd8; #1;
    chk("mflo", 64'(hl_out), 64'(ml));
    md_op = 4'd0; #1;
    chk("hl_none", 64'(hl_out), 64'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    int sel;
    sel = int'($urandom_range(0, 7));
    case (sel)
      0:       return '0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return W'($urandom_range(0, 9));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int op;
    int lat;
    int stop_at;
    bit use_rst;
    int iop;
    reset = 1'b1; md_op = 4'd0; rs = '0; rt = '0; cancel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_div_zero", 64'(div_zero), 64'(0));
    chk("rst_start", 64'(start), 64'(0));
    mon_en = 1'b1;

    issue(1, 32'hFFFFFFFE, 32'd3, 0, 1'b0, 0);
    chk("mult_hi", 64'(hi), 64'h0FFFFFFFF);
    chk("mult_lo", 64'(lo), 64'h0FFFFFFFA);
    readback();

    issue(3, 32'hFFFFFFF9, 32'd2, 0, 1'b0, 0);
    chk("div_lo", 64'(lo), 64'h0FFFFFFFD);
    chk("div_hi", 64'(hi), 64'h0FFFFFFFF);
    issue(4, 32'd7, 32'd2, 0, 1'b0, 0);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd1);

    mt(6, 32'h1234, 1'b0);
    issue(3, 32'd5, 32'd0, 0, 1'b0, 0);
    chk("dz_lo_kept", 64'(lo), 64'h1234);

    issue(1, 32'h12345, 32'h777, 2, 1'b0, 1);
    chk("cancel_lo_kept", 64'(lo), 64'h1234);

    md_op = 4'd1; rs = 32'd9; rt = 32'd9; cancel = 1'b1;
    @(posedge clk); #1;
    md_op = 4'd0; cancel = 1'b0;
    chk("start_cancel_busy", 64'(busy), 64'(0));

    issue(4, 32'd100, 32'd7, 3, 1'b1, 0);
    chk("reset_mid_hi", 64'(hi), 64'(0));
    chk("reset_mid_lo", 64'(lo), 64'(0));
    mt(5, 32'hAA, 1'b0);
    chk("mthi_after_reset", 64'(hi), 64'hAA);
    mt(6, 32'h55, 1'b1);

    issue(3, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0, 0);
    chk("minneg_lo", 64'(lo), 64'h080000000);
    chk("minneg_hi", 64'(hi), 64'(0));

`ifdef MDU_MADD_EN
    mt(5, 32'h0, 1'b0);
    mt(6, 32'hFFFFFFFF, 1'b0);
    issue(9, 32'd1, 32'd1, 0, 1'b0, 0);
    chk("madd_hi", 64'(hi), 64'd1);
    chk("madd_lo", 64'(lo), 64'd0);
`else
    md_op = 4'd9; rs = 32'd1; rt = 32'd1;
    #1;
    chk("madd_off_start", 64'(start), 64'(0));
    @(posedge clk); #1;
    md_op = 4'd0;
    chk("madd_off_busy", 64'(busy), 64'(0));
    chk("madd_off_hi", 64'(hi), 64'(mh));
    chk("madd_off_lo", 64'(lo), 64'(ml));
`endif

    for (int n = 0; n < 80; n++) begin
`ifdef MDU_MADD_EN
      op = int'($urandom_range(1, 10));
      if (op > 6) op = op + 2;
`else
      op = int'($urandom_range(1, 6));
`endif
      if (op == 5 || op == 6) begin
        mt(op, pick(), 1'b0);
      end else begin
        lat = (op == 3 || op == 4) ? DL : ML;
        stop_at = 0;
        use_rst = 1'b0;
        if ($urandom_range(0, 4) == 0) begin
          stop_at = int'($urandom_range(1, lat - 1));
          use_rst = ($urandom_range(0, 7) == 0);
        end
        iop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
        issue(op, pick(), pick(), stop_at, use_rst, iop);
      end
      readback();
    end

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
